mac_vector_engine: RTL and testbench
====================================

Name: mac_vector_engine

Overview:
- Parametrised successor to the single-lane nibble MAC.
- Holds two operand banks, A and B, each DEPTH entries of DW bits.
- The host loads operands one word per cycle, then issues a vector instruction: dot product, accumulating dot product, max-product or clear.
- Result sits in an AW-bit saturating accumulator. Sits directly under the Tiny Tapeout top wrapper, driven from ui_in/uio_in pins.

Parameters:
DW, 4, operand width in bits.
DEPTH, 8, entries per bank; power of two, 2..16.
AW, 12, accumulator/output width; must be >= 2*DW.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
load  in  1  write strobe for operand banks.
run  in  1  start strobe; sampled only in IDLE.
insn  in  2  opcode, sampled with run: 00 DOT, 01 DOTACC, 10 MAX, 11 CLR.
index  in  $clog2(DEPTH)+1  on load: MSB selects bank (0=A, 1=B), low bits select entry. On run: low bits give len-1.
data  in  DW  operand write data.
out  out  AW  accumulator value.
busy  out  1  instruction in progress.
done  out  1  one-cycle completion pulse.
sat  out  1  sticky saturation flag.

Behaviour:
- Reset (async assert, sync release): state IDLE; acc, out, busy, done, sat all 0; all bank entries 0. Reset mid-instruction aborts it with no partial result retained.
- Load: in IDLE with load=1, bank[index MSB][index low] <= data at the clock edge. Loads while busy=1 are ignored.
- Start: run=1 in IDLE latches insn and len = index[low]+1 (1..DEPTH) at edge E0. busy=1 from E0.
  - run while busy is ignored.
  - load and run in the same IDLE cycle: the write happens at E0 and the instruction sees the new value.
- FSM states: IDLE -> RUN -> DRAIN -> DONE -> IDLE (CLR goes IDLE -> DONE).
- RUN: 2-stage pipeline.
  - At edge E(i+1), prod <= A[i]*B[i] (unsigned, 2*DW bits), for i = 0..len-1.
  - At edge E(i+2), acc is updated with prod.
  - DRAIN is the single cycle that consumes the last product.
- Per-opcode acc update:
  - DOT: acc and sat clear at E0, then acc <= sat_add(acc, prod).
  - DOTACC: same as DOT, but starts from the current acc; sat is not cleared.
  - MAX: acc cleared at E0, then acc <= max(acc, prod); never saturates; sat cleared at E0.
  - CLR: acc <= 0 and sat <= 0 at E0.
- Saturating add: if the true sum > 2^AW-1, acc <= 2^AW-1 and sat <= 1. sat stays set until DOT, MAX or CLR.
- Completion: done=1 for exactly one cycle, between edges E(len+2) and E(len+3); CLR: between E1 and E2. busy falls at the same edge done falls. out equals the final acc throughout the done cycle.
- out is a registered copy of acc, updated every accumulate edge, so intermediate sums are visible.
- Banks are unchanged by all instructions.
- Index aliasing: len-1 uses the low $clog2(DEPTH) bits only; the MSB is ignored on run.

Test Plan:
1. Reset check: assert rst_n=0 mid-cycle with random inputs -> out=0, busy=0, done=0, sat=0 immediately; after release, DOT with len=8 -> out=0.
2. Basic DOT and timing: load A[0..3]=1,2,3,4 and B[0..3]=5,6,7,8; run DOT with index=3 -> done pulses exactly 6 cycles after E0 with out=70, busy high for 6 cycles.
3. DOTACC and MAX: repeat scenario 2 with DOTACC -> out=140, sat=0. Then MAX len=4 -> out=32.
4. Saturation: fill both banks with 15; DOT len=8 -> 1800; DOTACC -> 3600; DOTACC -> 4095 with sat=1. Then CLR -> out=0, sat=0, done 1 cycle after E0.
5. Guards: load and run pulsed during busy -> banks and result unaffected, no second done. Same-cycle load of A[0]=9 with run DOT len=1, B[0]=2 -> out=18.
6. Abort: assert rst_n mid-DOT -> all outputs 0, a subsequent DOT returns 0, done never fires for the aborted instruction.

Source files
------------

// File: rtl/mac_vector_engine_if.sv
// Host-side bus of the MAC vector engine: operand loads, instruction issue and
// result/status readback.
interface mac_vector_engine_if #(
    parameter int unsigned DW    = 4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 12
);
    localparam int unsigned IW = $clog2(DEPTH) + 1;

    logic          load;
    logic          run;
    logic [1:0]    insn;
    logic [IW-1:0] index;
    logic [DW-1:0] data;
    logic [AW-1:0] out;
    logic          busy;
    logic          done;
    logic          sat;

    modport master (
        output load, run, insn, index, data,
        input  out, busy, done, sat
    );

    modport slave (
        input  load, run, insn, index, data,
        output out, busy, done, sat
    );
endinterface

// File: rtl/mac_vector_engine.sv
// Two-bank vector MAC: per-element unsigned products through a 2-stage pipeline
// into a saturating (or max-tracking) accumulator.
module mac_vector_engine #(
    parameter int unsigned DW    = 4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 12
) (
    input logic               clk,
    input logic               rst_n,
    mac_vector_engine_if.slave bus
);
    localparam int unsigned LW = $clog2(DEPTH);
    localparam int unsigned PW = 2 * DW;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;
    typedef enum logic [1:0] {OpDot = 2'b00, OpDotAcc = 2'b01, OpMax = 2'b10, OpClr = 2'b11} op_e;

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [LW-1:0] len_m1_q, len_m1_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] prod_q, prod_d;
    logic          prod_vld_q, prod_vld_d;
    logic [AW-1:0] acc_q, acc_d;
    logic          sat_q, sat_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW-1:0] bank_a_q [DEPTH];
    logic [DW-1:0] bank_a_d [DEPTH];
    logic [DW-1:0] bank_b_q [DEPTH];
    logic [DW-1:0] bank_b_d [DEPTH];

    logic          accept;
    logic [AW:0]   sum;

    // busy_q also covers the done cycle, so requests are refused until it drops.
    assign accept = (state_q == StIdle) && !busy_q;
    assign sum    = {1'b0, acc_q} + (AW + 1)'(prod_q);

    always_comb begin
        bank_a_d   = bank_a_q;
        bank_b_d   = bank_b_q;
        state_d    = state_q;
        op_d       = op_q;
        len_m1_d   = len_m1_q;
        cnt_d      = cnt_q;
        prod_d     = prod_q;
        prod_vld_d = 1'b0;
        acc_d      = acc_q;
        sat_d      = sat_q;

        if (accept && bus.load) begin
            if (bus.index[LW]) bank_b_d[bus.index[LW-1:0]] = bus.data;
            else               bank_a_d[bus.index[LW-1:0]] = bus.data;
        end

        unique case (state_q)
            StIdle: begin
                if (accept && bus.run) begin
                    op_d     = op_e'(bus.insn);
                    len_m1_d = bus.index[LW-1:0];
                    cnt_d    = '0;
                    if (op_e'(bus.insn) != OpDotAcc) begin
                        acc_d = '0;
                        sat_d = 1'b0;
                    end
                    state_d = (op_e'(bus.insn) == OpClr) ? StDone : StRun;
                end
            end
            StRun: begin
                prod_d     = PW'(bank_a_q[cnt_q]) * PW'(bank_b_q[cnt_q]);
                prod_vld_d = 1'b1;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == len_m1_q) state_d = StDrain;
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (prod_vld_q) begin
            if (op_q == OpMax) begin
                if (AW'(prod_q) > acc_q) acc_d = AW'(prod_q);
            end else if (sum[AW]) begin
                acc_d = '1;
                sat_d = 1'b1;
            end else begin
                acc_d = sum[AW-1:0];
            end
        end

        // Outputs trail the FSM by one edge, hence done lands after DONE state.
        done_d = (state_q == StDone);
        busy_d = (state_d != StIdle) || done_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            op_q       <= OpDot;
            len_m1_q   <= '0;
            cnt_q      <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
            sat_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                bank_a_q[i] <= '0;
                bank_b_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            len_m1_q   <= len_m1_d;
            cnt_q      <= cnt_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q      <= acc_d;
            sat_q      <= sat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bank_a_q   <= bank_a_d;
            bank_b_q   <= bank_b_d;
        end
    end

    assign bus.out  = acc_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sat  = sat_q;
endmodule

// File: tb/tb_mac_vector_engine.sv
// Directed bench for mac_vector_engine with an instruction-level reference model
// and a per-cycle handshake/result monitor.
module tb_mac_vector_engine;
    localparam int unsigned DW    = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 12;
    localparam int unsigned LW    = 3;
    localparam longint      MAXV  = (64'd1 << AW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mac_vector_engine_if #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) bus ();

    mac_vector_engine #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    int            ma [DEPTH];
    int            mb [DEPTH];
    logic [AW-1:0] m_acc;
    logic          m_sat;
    int            cyc = 0;
    int            e0 = 0;
    int            done_at = 0;
    bit            active = 1'b0;
    bit            chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Whole-instruction effect: the final accumulator/flag and when done must pulse.
    task automatic model_issue(input int op, input int lenm1);
        longint s  = 0;
        longint mx = 0;
        longint p;
        for (int i = 0; i <= lenm1; i++) begin
            p = longint'(ma[i]) * longint'(mb[i]);
            s += p;
            if (p > mx) mx = p;
        end
        case (op)
            0: begin
                m_sat = (s > MAXV);
                m_acc = (s > MAXV) ? AW'(MAXV) : AW'(s);
            end
            1: begin
                s += longint'(m_acc);
                if (s > MAXV) begin
                    m_acc = AW'(MAXV);
                    m_sat = 1'b1;
                end else begin
                    m_acc = AW'(s);
                end
            end
            2: begin
                m_acc = AW'(mx);
                m_sat = 1'b0;
            end
            default: begin
                m_acc = '0;
                m_sat = 1'b0;
            end
        endcase
        e0      = cyc;
        done_at = (op == 3) ? cyc + 1 : cyc + lenm1 + 3;
        active  = 1'b1;
    endtask

    task automatic model_reset();
        active = 1'b0;
        m_acc  = '0;
        m_sat  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ma[i] = 0;
            mb[i] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && chk_en) begin : monitor
            bit bx;
            bit dx;
            bx = active && (cyc >= e0) && (cyc <= done_at);
            dx = active && (cyc == done_at);
            n_checks++;
            if (bus.busy !== bx || bus.done !== dx) begin
                n_fail++;
                $display("FAIL handshake cyc=%0d: busy=%b done=%b, expected busy=%b done=%b",
                         cyc, bus.busy, bus.done, bx, dx);
            end
            if (!bx || dx) begin
                n_checks++;
                if (bus.out !== m_acc || bus.sat !== m_sat) begin
                    n_fail++;
                    $display("FAIL result cyc=%0d: out=%0d sat=%b, expected out=%0d sat=%b",
                             cyc, bus.out, bus.sat, m_acc, m_sat);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input bit bank, input int idx, input int val);
        bus.load  = 1'b1;
        bus.index = {bank, LW'(idx)};
        bus.data  = DW'(val);
        tick();
        bus.load = 1'b0;
        if (bank) mb[idx] = val;
        else      ma[idx] = val;
    endtask

    // idx doubles as the load address when ld is set (same-cycle load+run).
    task automatic run_op(input string name, input int op, input int idx, input bit ld,
                          input int ld_dat, input bit guard, input int exp_out,
                          input bit exp_sat, input int exp_busy);
        int nb  = 0;
        bit got = 1'b0;
        bus.run   = 1'b1;
        bus.insn  = 2'(op);
        bus.index = (LW + 1)'(idx);
        if (ld) begin
            bus.load = 1'b1;
            bus.data = DW'(ld_dat);
        end
        tick();
        bus.run  = 1'b0;
        bus.load = 1'b0;
        if (ld) begin
            if (idx >= DEPTH) mb[idx % DEPTH] = ld_dat;
            else              ma[idx] = ld_dat;
        end
        model_issue(op, idx % DEPTH);
        if (guard) begin
            bus.load  = 1'b1;
            bus.run   = 1'b1;
            bus.insn  = 2'd3;
            bus.index = '0;
            bus.data  = 4'd3;
            tick();
            bus.load = 1'b0;
            bus.run  = 1'b0;
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) nb++;
        end
        check({name, " done_seen"}, 32'(got), 32'd1);
        check({name, " out"}, 32'(bus.out), 32'(exp_out));
        check({name, " sat"}, 32'(bus.sat), 32'(exp_sat));
        if (exp_busy >= 0) check({name, " busy_before_done"}, 32'(nb), 32'(exp_busy));
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.load  = 1'($urandom);
        bus.run   = 1'($urandom);
        bus.insn  = 2'($urandom);
        bus.index = 4'($urandom);
        bus.data  = 4'($urandom);
        model_reset();
        #3;
        check("reset out", 32'(bus.out), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset sat", 32'(bus.sat), 32'd0);
        tick();
        tick();
        bus.load = 1'b0;
        bus.run  = 1'b0;
        rst_n    = 1'b1;
        chk_en   = 1'b1;
        tick();

        run_op("dot8_after_reset", 0, 7, 1'b0, 0, 1'b0, 0, 1'b0, 10);

        for (int i = 0; i < 4; i++) begin
            load_w(1'b0, i, i + 1);
            load_w(1'b1, i, i + 5);
        end
        run_op("dot4", 0, 3, 1'b0, 0, 1'b0, 70, 1'b0, 6);
        run_op("dotacc4", 1, 3, 1'b0, 0, 1'b0, 140, 1'b0, 6);
        run_op("max4", 2, 3, 1'b0, 0, 1'b0, 32, 1'b0, -1);

        for (int i = 0; i < DEPTH; i++) begin
            load_w(1'b0, i, 15);
            load_w(1'b1, i, 15);
        end
        run_op("dot8_full", 0, 7, 1'b0, 0, 1'b0, 1800, 1'b0, -1);
        run_op("dotacc8_a", 1, 7, 1'b0, 0, 1'b0, 3600, 1'b0, -1);
        run_op("dotacc8_sat", 1, 7, 1'b0, 0, 1'b0, 4095, 1'b1, -1);
        run_op("dotacc_sticky", 1, 0, 1'b0, 0, 1'b0, 4095, 1'b1, -1);
        run_op("clr", 3, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1);

        load_w(1'b1, 0, 2);
        // MSB of idx set on run: ignored for len, so this is len=2.
        run_op("dot2_guarded", 0, 9, 1'b0, 0, 1'b1, 255, 1'b0, -1);
        run_op("dot1_bank_intact", 0, 0, 1'b0, 0, 1'b0, 30, 1'b0, 3);
        run_op("dot1_same_cycle_load", 0, 0, 1'b1, 9, 1'b0, 18, 1'b0, -1);

        bus.run   = 1'b1;
        bus.insn  = 2'd0;
        bus.index = 4'd7;
        tick();
        bus.run = 1'b0;
        model_issue(0, 7);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("abort out", 32'(bus.out), 32'd0);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort sat", 32'(bus.sat), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_op("dot8_after_abort", 0, 7, 1'b0, 0, 1'b0, 0, 1'b0, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
